instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Consumer side of the program counter: turns pc_out into instruction-memory reads.
//   Buffers returned instructions with their PC, in order, for the decode stage.
//   Drives the PC stall input whenever no fetch is issued.
//   Flushes wrong-path work on branch, including reads already in flight to memory.
// PARAMETERS
//   ADDR_W  10  instruction address width (matches PC)
//   DATA_W  16  instruction word width
//   DEPTH   4   queue entries; power of 2, >= 2
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       synchronous, active-high
//   pc_in        in   ADDR_W  current PC register value
//   branch       in   1       redirect; same signal that loads branch_address into PC
//   pc_stall     out  1       to PC stall; high = hold PC
//   imem_req     out  1       read request, one per cycle max
//   imem_addr    out  ADDR_W  read address (= pc_in)
//   imem_rdata   in   DATA_W  read data
//   imem_rvalid  in   1       read data valid; in order, latency >= 1 cycle
//   dec_valid    out  1       head entry filled and valid
//   dec_instr    out  DATA_W  head instruction
//   dec_pc       out  ADDR_W  PC of head instruction
//   dec_ready    in   1       decode accepts head; pop when dec_valid & dec_ready
// BEHAVIOUR
//   - State: pointers alloc, fill and rd, each $clog2(DEPTH)+1 bits, wrapping mod 2*DEPTH.
//     Also drop counter drop, same width. Per entry: pc[ADDR_W], instr[DATA_W].
//   - Derived values: used = alloc - rd; inflight = alloc - fill; all arithmetic is modulo the pointer width.
//   - Issue: issue = !reset & !branch & (used < DEPTH), from registered state only.
//     dec_ready does not reach imem_req combinationally.
//     imem_req = issue; imem_addr = pc_in; pc_stall = !issue.
//     On issue, entry[alloc].pc <= pc_in and alloc++.
//   - Response, when imem_rvalid:
//     drop > 0: discard the data and decrement drop.
//     Else if inflight > 0: entry[fill].instr <= imem_rdata and fill++.
//     Else: protocol error; ignore, assertion fires.
//   - Output: dec_valid = (fill != rd) & !branch; dec_instr/dec_pc = entry[rd]. Pop increments rd.
//   - Latency: response in cycle N makes dec_valid high in N+1. Empty-queue fetch-to-decode is 1 + memory latency.
//   - Branch has priority over all other updates:
//     alloc, fill and rd all <= 0.
//     drop <= drop + inflight - (imem_rvalid ? 1 : 0), counting every outstanding wrong-path read.
//     No issue and no pop that cycle. Next cycle pc_in is the branch target and fetch resumes.
//   - Full (used == DEPTH): stall held. A pop in the same cycle frees the slot for the next cycle, not this one.
//   - Same cycle push, fill and pop: all three are applied; they are independent pointers.
//   - Wrap: the extra pointer MSB distinguishes full from empty; DEPTH=4 wraps at 8.
//   - Reset, including mid-operation: all pointers and drop <= 0.
//     During reset: imem_req=0, pc_stall=1, dec_valid=0.
//     Responses after reset with inflight==0 and drop==0 are ignored. The memory is reset on the same reset.
//   - Entry storage is not reset; only the pointers qualify validity.
// STRUCTURE
//   - Shared header fetch_defs.vh: ADDR_W/DATA_W defaults and the NOP encoding. The PC, decode and this block use it.
//   - One sub-module, fetch_ptr: wrapping pointer with inc and clr inputs and a synchronous reset. Instantiated 3x.
//   - Entry array and drop counter live in the top level.
// TESTING
//   1. Reset held 3 cycles with imem_rvalid pulsed -> imem_req=0, pc_stall=1, dec_valid=0. No entry appears afterwards.
//   2. Latency-1 memory, dec_ready=1, PC 0,1,2,... -> dec_pc 0,1,2 with matching instr. Sustained 1 instr/cycle, pc_stall=0.
//   3. dec_ready=0, DEPTH=4 -> exactly 4 requests (PC 0-3), then pc_stall=1.
//      Raise dec_ready -> pop PC 0; request for PC 4 issues the following cycle.
//   4. Latency-3 memory, 2 reads in flight, branch to 0x200 -> both late responses dropped (drop 2->0).
//      First dec_pc after branch is 0x200.
//   5. Branch in the same cycle as imem_rvalid and dec_ready with a full queue -> nothing popped, that response dropped.
//      drop equals the remaining inflight count.
//   6. 20 pushes/pops at DEPTH=4 -> pointers wrap past 7; order and PC/instr pairing preserved. No spurious full or empty.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared fetch widths, NOP encoding and response classification
package instr_fetch_queue_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_DROP,
    RSP_FILL,
    RSP_ORPHAN
  } rsp_kind_e;

  // Wrong-path reads are retired before any live entry, since memory returns in order.
  function automatic rsp_kind_e rsp_classify(input logic rvalid,
                                             input logic drop_nz,
                                             input logic inflight_nz);
    rsp_kind_e kind;
    kind = RSP_NONE;
    if (rvalid) begin
      if (drop_nz)          kind = RSP_DROP;
      else if (inflight_nz) kind = RSP_FILL;
      else                  kind = RSP_ORPHAN;
    end
    return kind;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_ptr.sv
// rtl/instr_fetch_queue_fetch_ptr.sv - wrapping queue pointer with increment and clear
module fetch_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Clear wins over increment so a branch discards the same-cycle push or pop.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - issues instruction reads from the PC and queues in-order results for decode
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              branch,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);

  logic [PW-1:0] alloc_q, fill_q, rd_q;
  logic [PW-1:0] drop_q, drop_d;
  logic [PW-1:0] used, inflight;

  logic [ADDR_W-1:0] entry_pc_q    [DEPTH];
  logic [DATA_W-1:0] entry_instr_q [DEPTH];

  logic      issue;
  logic      fill_en;
  logic      pop;
  rsp_kind_e rsp_kind;

  assign used     = alloc_q - rd_q;
  assign inflight = alloc_q - fill_q;

  // Issue depends only on registered occupancy, never on dec_ready.
  assign issue     = !reset && !branch && (used < DEPTH_PTR);
  assign imem_req  = issue;
  assign imem_addr = pc_in;
  assign pc_stall  = !issue;

  assign rsp_kind = rsp_classify(imem_rvalid, drop_q != '0, inflight != '0);
  assign fill_en  = (rsp_kind == RSP_FILL) && !branch && !reset;

  assign dec_valid = (fill_q != rd_q) && !branch && !reset;
  assign pop       = dec_valid && dec_ready;
  assign dec_pc    = entry_pc_q[rd_q[IW-1:0]];
  assign dec_instr = dec_valid ? entry_instr_q[rd_q[IW-1:0]] : NOP_INSTR;

  fetch_ptr #(.W(PW)) u_alloc_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (issue),
    .clr_i (branch),
    .ptr_o (alloc_q)
  );

  fetch_ptr #(.W(PW)) u_fill_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (fill_en),
    .clr_i (branch),
    .ptr_o (fill_q)
  );

  fetch_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pop),
    .clr_i (branch),
    .ptr_o (rd_q)
  );

  // On branch every outstanding read becomes wrong-path; a response arriving now retires one of them.
  always_comb begin
    drop_d = drop_q;
    if (branch) begin
      if (rsp_kind == RSP_DROP || rsp_kind == RSP_FILL) drop_d = drop_q + inflight - PW'(1);
      else                                             drop_d = drop_q + inflight;
    end else if (rsp_kind == RSP_DROP) begin
      drop_d = drop_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  // Entry storage is never reset; pointers alone say which slots hold live data.
  always_ff @(posedge clk) begin
    if (issue)   entry_pc_q[alloc_q[IW-1:0]]   <= pc_in;
    if (fill_en) entry_instr_q[fill_q[IW-1:0]] <= imem_rdata;
  end

  a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
    rsp_kind != RSP_ORPHAN);

  a_occupancy_bounded: assert property (@(posedge clk) disable iff (reset)
    (used <= DEPTH_PTR) && (inflight <= used));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed table and sequence bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic [9:0]  pc_in;
  logic        branch;
  logic        pc_stall;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [9:0]  dec_pc;
  logic        dec_ready;

  instr_fetch_queue #(.ADDR_W(10), .DATA_W(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .branch      (branch),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       br;
    logic [9:0] tgt;
    logic       rdy;
    logic       frv;
    logic       e_req;
    logic       e_stall;
    logic       e_dv;
    logic [9:0] e_dpc;
  } vec_t;

  vec_t       tbl [18];
  logic [9:0] q_addr [$];
  int         q_due  [$];
  int         cnt, lat, errors, checks, pops, p0;
  logic [9:0] pc_m, exp_pc;

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    return {a[5:0], a} ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, model memory/PC, sample outputs at the falling edge.
  task automatic step(input logic r, input logic b, input logic [9:0] t,
                      input logic rdy, input logic frv);
    @(posedge clk); #1;
    cnt++;
    reset = r; branch = b; dec_ready = rdy; pc_in = pc_m;
    imem_rvalid = 1'b0; imem_rdata = '0;
    if (r) begin
      q_addr.delete(); q_due.delete();
      imem_rvalid = frv; imem_rdata = 16'hDEAD;
    end else if (q_due.size() > 0 && q_due[0] == cnt) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(q_addr[0]);
      q_addr.delete(0); q_due.delete(0);
    end
    @(negedge clk);
    if (imem_req) begin
      check("imem_addr", 32'(imem_addr), 32'(pc_m));
      q_addr.push_back(imem_addr); q_due.push_back(cnt + lat);
    end
    if (dec_valid && rdy) begin
      check("pop_pc", 32'(dec_pc), 32'(exp_pc));
      check("pop_instr", 32'(dec_instr), 32'(mem_word(exp_pc)));
      exp_pc++; pops++;
    end
    if (r)              begin pc_m = '0; exp_pc = '0; end
    else if (b)         begin pc_m = t;  exp_pc = t;  end
    else if (!pc_stall) pc_m++;
  endtask

  initial begin
    errors = 0; checks = 0; pops = 0; cnt = 0; lat = 1;
    pc_m = '0; exp_pc = '0;
    reset = 1'b1; branch = 1'b0; dec_ready = 1'b0; pc_in = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    //          rst   br    tgt    rdy   frv   req   stall dv    dpc
    tbl[0]  = '{1'b1, 1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0};
    tbl[1]  = '{1'b1, 1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0};
    tbl[2]  = '{1'b1, 1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0};
    tbl[3]  = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0};
    tbl[4]  = '{1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0};
    tbl[5]  = '{1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0};
    tbl[6]  = '{1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h1};
    tbl[7]  = '{1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h2};
    tbl[8]  = '{1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0};
    tbl[9]  = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0};
    tbl[10] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0};
    tbl[11] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0};
    tbl[12] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0};
    tbl[13] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0};
    tbl[14] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0};
    tbl[15] = '{1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0};
    tbl[16] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h1};
    tbl[17] = '{1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h1};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].frv);
      check($sformatf("v%0d_req", i),   32'(imem_req),  32'(tbl[i].e_req));
      check($sformatf("v%0d_stall", i), 32'(pc_stall),  32'(tbl[i].e_stall));
      check($sformatf("v%0d_dv", i),    32'(dec_valid), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv) check($sformatf("v%0d_dpc", i), 32'(dec_pc), 32'(tbl[i].e_dpc));
    end

    // Latency-3 memory, two reads in flight, branch to 0x200.
    lat = 3;
    step(1'b1, 1'b0, 10'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 10'h200, 1'b1, 1'b0);
    check("br4_req", 32'(imem_req), 32'd0);
    check("br4_dv", 32'(dec_valid), 32'd0);
    p0 = pops;
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br4_drop2", 32'(dut.drop_q), 32'd2);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br4_drop1", 32'(dut.drop_q), 32'd1);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br4_drop0", 32'(dut.drop_q), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br4_pops", 32'(pops - p0), 32'd2);

    // Full queue; branch coincides with a response and dec_ready.
    step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    check("br5_full_stall", 32'(pc_stall), 32'd1);
    p0 = pops;
    step(1'b0, 1'b1, 10'h100, 1'b1, 1'b0);
    check("br5_rvalid_seen", 32'(imem_rvalid), 32'd1);
    check("br5_dv", 32'(dec_valid), 32'd0);
    check("br5_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br5_drop1", 32'(dut.drop_q), 32'd1);
    step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br5_drop0", 32'(dut.drop_q), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    check("br5_pops", 32'(pops - p0), 32'd1);

    // Sustained streaming and pointer wrap at latency 1.
    lat = 1;
    step(1'b1, 1'b0, 10'h0, 1'b1, 1'b0);
    p0 = pops;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
      check($sformatf("wrap_stall%0d", i), 32'(pc_stall), 32'd0);
      if (i >= 2) check($sformatf("wrap_dv%0d", i), 32'(dec_valid), 32'd1);
    end
    check("wrap_pops", 32'(pops - p0), 32'd28);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 10'h0, (i % 3) != 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
